mem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-side and data-side cache miss paths of the pipeline. Accepts one outstanding request per requester, grants one at a time, drives the memory interface for a fixed access latency, then returns read data and a one-cycle acknowledge. Sits between the two cache units and main memory. While a requester waits for its acknowledge, its cache keeps `hit` low, so the pipeline stays frozen through the existing `freeze` path.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one main-memory port between the I-side and D-side cache miss
//   paths. It accepts one request at a time and holds the memory interface
//   for MEM_LATENCY cycles. It then returns read data with a one-cycle ack.
//
//   Parameters:
//     MEM_LATENCY    memory access cycles per transfer (1..15)
//   Build option:
//     ARB_ROUND_ROBIN_EN  defined   -> a tie goes to the side not granted last
//                         undefined -> fixed priority, D over I
//   Ports:
//     clk, rst_b         clock; asynchronous active-high reset
//     i_req/i_addr       I-side read request and word address
//     i_ack/i_rdata      I-side completion pulse and read data
//     d_req/d_we/d_addr/d_wdata  D-side request, direction, address, data
//     d_ack/d_rdata      D-side completion pulse and read data
//     mem_en/mem_write_en/mem_addr/mem_wdata/mem_rdata  memory port
//     busy               high while a transfer is in BUSY or DONE
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_d_q, gnt_d_d;      // 1: D side owns the current transfer
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        grant_d;               // D side wins this IDLE evaluation

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d_q, last_d_d;    // last grant went to D

  assign grant_d = d_req & (~i_req | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  // The mem_* registers double as the latched request; they hold the
  // granted address/we/wdata for the whole BUSY phase.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d_d     = gnt_d_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d     = BUSY;
          cnt_d       = CNT_LOAD;
          gnt_d_d     = grant_d;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_d & d_we;
          mem_addr_d  = grant_d ? d_addr : i_addr;
          mem_wdata_d = grant_d ? d_wdata : '0;
          busy_d      = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d    = grant_d;
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == '0) begin
          cnt_d       = '0;
          state_d     = DONE;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (gnt_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_d_q     <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_d_q     <= gnt_d_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign i_ack        = i_ack_q;
  assign d_ack        = d_ack_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign mem_en       = mem_en_q;
  assign mem_write_en = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a directed sequence plus randomized
// transfers, checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned L  = 4;
  localparam int unsigned L2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, mem_en, mem_write_en, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic        i_req2, d_req2, d_we2;
  logic [31:0] i_addr2, d_addr2, d_wdata2;
  logic        i_ack2, d_ack2, mem_en2, mem_write_en2, busy2;
  logic [31:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;
  logic [31:0] mem_rdata2 = 32'h0;

  mem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(L2)) dut2 (
    .clk(clk), .rst_b(rst_b),
    .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2), .i_rdata(i_rdata2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_ack(d_ack2), .d_rdata(d_rdata2),
    .mem_en(mem_en2), .mem_write_en(mem_write_en2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Memory model: the read word is a fixed function of the address and is
  // only presented in the last cycle of an access; other cycles carry junk.
  function automatic logic [31:0] rd_value(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  logic        force_en  = 1'b0;
  logic [31:0] force_val = 32'h0;
  int unsigned bcnt = 0, bcnt2 = 0;

  always @(posedge clk) begin
    #1;
    if (mem_en === 1'b1) begin
      bcnt++;
      mem_rdata = (bcnt == L) ? (force_en ? force_val : rd_value(mem_addr))
                              : (32'hBAD0_0000 | bcnt);
    end else begin
      bcnt = 0;
      mem_rdata = 32'hBADB_AD00;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mem_en2 === 1'b1) begin
      bcnt2++;
      mem_rdata2 = (bcnt2 == L2) ? rd_value(mem_addr2) : (32'hBAD1_0000 | bcnt2);
    end else begin
      bcnt2 = 0;
      mem_rdata2 = 32'hBADB_AD11;
    end
  end

  // Reference state: who was granted last, and the rdata each side should hold.
  bit          last_d_m = 1'b0;
  logic [31:0] exp_i_rd = '0;
  logic [31:0] exp_d_rd = '0;

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_mem_en", mem_en, 1'b0);
      chk1("idle_i_ack", i_ack, 1'b0);
      chk1("idle_d_ack", d_ack, 1'b0);
    end
  endtask

  // Presents the requests, then follows the expected transfer sequence
  // cycle by cycle. Entry and exit: #1 after an edge, DUT in IDLE.
  task automatic run_txn(input bit use_i, input bit use_d, input bit dwe,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] dwd);
    bit order [2];
    int unsigned n;
    i_req = use_i; i_addr = ia;
    d_req = use_d; d_we = dwe; d_addr = da; d_wdata = dwd;
    n = 0;
    order[0] = 1'b0;
    order[1] = 1'b0;
    if (use_i && use_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      order[0] = !last_d_m;
`else
      order[0] = 1'b1;
`endif
      order[1] = !order[0];
      n = 2;
    end else if (use_d) begin
      order[0] = 1'b1; n = 1;
    end else if (use_i) begin
      order[0] = 1'b0; n = 1;
    end
    for (int unsigned k = 0; k < n; k++) begin
      bit          sd;
      bit          we;
      logic [31:0] a;
      sd = order[k];
      a  = sd ? da : ia;
      we = sd & dwe;
      last_d_m = sd;
      for (int unsigned c = 1; c <= L + 1; c++) begin
        @(posedge clk); #1;
        if (c == L + 1 && !we) begin
          if (sd) exp_d_rd = force_en ? force_val : rd_value(a);
          else    exp_i_rd = force_en ? force_val : rd_value(a);
        end
        chk1("busy", busy, 1'b1);
        chk1("mem_en", mem_en, c <= L);
        chk1("mem_write_en", mem_write_en, (c <= L) && we);
        if (c <= L) begin
          chk("mem_addr", mem_addr, a);
          if (sd) chk("mem_wdata", mem_wdata, dwd);
        end
        chk1("i_ack", i_ack, (c == L + 1) && !sd);
        chk1("d_ack", d_ack, (c == L + 1) && sd);
        chk("i_rdata", i_rdata, exp_i_rd);
        chk("d_rdata", d_rdata, exp_d_rd);
        if (c == L + 1) begin
          if (sd) d_req = 1'b0;
          else    i_req = 1'b0;
        end
      end
      idle_cycles(1);
    end
  endtask

  initial begin
    logic [31:0] a2;
    rst_b = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    i_req2 = 0; d_req2 = 0; d_we2 = 0; i_addr2 = '0; d_addr2 = '0; d_wdata2 = '0;
    #1;
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_write_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b0;
    @(posedge clk); #1;

    // I-side read with a known memory word
    force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
    chk("i_rdata_deadbeef", i_rdata, 32'hDEAD_BEEF);
    force_en = 1'b0;
    idle_cycles(2);

    // D read, then a D write that must leave d_rdata alone
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'h1234_5678);
    chk("d_rdata_after_write", d_rdata, rd_value(32'h200));

    // simultaneous requests, then repeated ties
    run_txn(1'b1, 1'b1, 1'b0, 32'h80, 32'h300, 32'h0);
    run_txn(1'b1, 1'b1, 1'b1, 32'h84, 32'h304, 32'hCAFE_0001);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h308, 32'h0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h88, 32'h30C, 32'h0);
    run_txn(1'b1, 1'b0, 1'b0, 32'h8C, 32'h0, 32'h0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h90, 32'h310, 32'h0);

    // randomized traffic
    for (int r = 0; r < 24; r++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    // reset during the second BUSY cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h444;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("pre_rst_mem_en", mem_en, 1'b1);
    #1 rst_b = 1'b1;
    #1;
    chk1("arst_mem_en", mem_en, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_d_rdata", d_rdata, 32'h0);
    chk("arst_i_rdata", i_rdata, 32'h0);
    d_req = 1'b0;
    last_d_m = 1'b0; exp_i_rd = '0; exp_d_rd = '0;
    @(posedge clk); #1;
    chk1("rst_hold_d_ack", d_ack, 1'b0);
    chk1("rst_hold_i_ack", i_ack, 1'b0);
    @(negedge clk) rst_b = 1'b0;
    idle_cycles(1);
    run_txn(1'b1, 1'b1, 1'b0, 32'h448, 32'h444, 32'h0);

    // MEM_LATENCY=1 instance: back-to-back D reads, ack every 3 cycles
    a2 = $urandom;
    d_req2 = 1'b1; d_we2 = 1'b0; d_addr2 = a2;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk1("l1_busy_mem_en", mem_en2, 1'b1);
      chk("l1_mem_addr", mem_addr2, a2);
      chk1("l1_busy_ack", d_ack2, 1'b0);
      @(posedge clk); #1;
      chk1("l1_ack", d_ack2, 1'b1);
      chk("l1_d_rdata", d_rdata2, rd_value(a2));
      chk1("l1_done_mem_en", mem_en2, 1'b0);
      a2 = $urandom;
      d_addr2 = a2;
      if (t == 4) d_req2 = 1'b0;
      @(posedge clk); #1;
      chk1("l1_idle_ack", d_ack2, 1'b0);
      chk1("l1_idle_busy", busy2, 1'b0);
    end
    chk1("l1_i_ack", i_ack2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
